// File: rtl/ag_pkg.sv
// Shared types and helpers for the checkerboard pattern generator.
package ag_pkg;

  typedef enum logic {PASS_DIRECT, PASS_INVERSE} ag_pass_t;

  localparam int AG_MAX_W = 1024;

  // Base word A: even bit positions set, odd cleared (8 bits -> 8'h55).
  function automatic logic [AG_MAX_W-1:0] checker_word(input int width);
    logic [AG_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < AG_MAX_W; i++)
      if (i < width) w[i] = ~i[0];
    return w;
  endfunction

endpackage

// File: rtl/ag_checkerboard.sv
// Checkerboard test-pattern generator: LENGTH-word direct pass, then its
// inverse, repeating while enabled. All outputs registered.
module ag_checkerboard
  import ag_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int LENGTH        = 8,
  parameter bit INVERT_VALUES = 1'b0
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             enbl_i,
  output logic             started_all_o,
  output logic             started_part_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             wr_enbl_o
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(LENGTH - 1);
  localparam logic [AG_MAX_W-1:0] A_FULL = checker_word(WIDTH);
  localparam logic [WIDTH-1:0] WORD_A = A_FULL[WIDTH-1:0];

  logic [CW-1:0]    k_q;
  ag_pass_t         pass_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             en_q, part_q, all_q;
  logic             flip;

  // Each of word parity, inverse pass and INVERT_VALUES complements the base word.
  always_comb begin
    flip   = k_q[0] ^ (pass_q == PASS_INVERSE) ^ INVERT_VALUES;
    data_d = flip ? ~WORD_A : WORD_A;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      k_q    <= '0;
      pass_q <= PASS_DIRECT;
      data_q <= '0;
      en_q   <= 1'b0;
      part_q <= 1'b0;
      all_q  <= 1'b0;
    end else if (enbl_i) begin
      data_q <= data_d;
      en_q   <= 1'b1;
      part_q <= (k_q == '0);
      all_q  <= (k_q == '0) && (pass_q == PASS_DIRECT);
      if (k_q == K_LAST) begin
        k_q    <= '0;
        pass_q <= (pass_q == PASS_DIRECT) ? PASS_INVERSE : PASS_DIRECT;
      end else begin
        k_q <= k_q + 1'b1;
      end
    end else begin
      en_q   <= 1'b0;
      part_q <= 1'b0;
      all_q  <= 1'b0;
    end
  end

  assign wr_data_o      = data_q;
  assign wr_enbl_o      = en_q;
  assign started_part_o = part_q;
  assign started_all_o  = all_q;

endmodule

// File: tb/tb_ag_checkerboard.sv
// Randomized bench for ag_checkerboard over three parameter sets, checked
// against a word-count based reference model.
module tb_ag_checkerboard;

  logic clk = 1'b0;
  logic srst, enbl;
  always #5 clk = ~clk;

  localparam int NI = 3;
  int pw [NI] = '{8, 8, 5};
  int pl [NI] = '{8, 3, 1};
  int pinv [NI] = '{0, 1, 0};

  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [NI-1:0] g_en, g_part, g_all;
  logic [31:0] g_data [NI];

  ag_checkerboard #(.WIDTH(8), .LENGTH(8), .INVERT_VALUES(1'b0)) u0 (
    .clk_i(clk), .srst_i(srst), .enbl_i(enbl), .started_all_o(g_all[0]),
    .started_part_o(g_part[0]), .wr_data_o(d0), .wr_enbl_o(g_en[0]));
  ag_checkerboard #(.WIDTH(8), .LENGTH(3), .INVERT_VALUES(1'b1)) u1 (
    .clk_i(clk), .srst_i(srst), .enbl_i(enbl), .started_all_o(g_all[1]),
    .started_part_o(g_part[1]), .wr_data_o(d1), .wr_enbl_o(g_en[1]));
  ag_checkerboard #(.WIDTH(5), .LENGTH(1), .INVERT_VALUES(1'b0)) u2 (
    .clk_i(clk), .srst_i(srst), .enbl_i(enbl), .started_all_o(g_all[2]),
    .started_part_o(g_part[2]), .wr_data_o(d2), .wr_enbl_o(g_en[2]));

  assign g_data[0] = {24'd0, d0};
  assign g_data[1] = {24'd0, d1};
  assign g_data[2] = {27'd0, d2};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word n (counted from reset) of the endless stream.
  function automatic logic [31:0] exp_word(input int w, input int l, input int inv, input int n);
    int p, k, ps;
    logic [31:0] a, m;
    p = n % (2 * l);
    k = p % l;
    ps = p / l;
    a = '0; m = '0;
    for (int i = 0; i < w; i++) begin
      a[i] = (i % 2 == 0);
      m[i] = 1'b1;
    end
    return (((k % 2) ^ ps ^ inv) != 0) ? (~a & m) : a;
  endfunction

  int          cnt [NI];
  logic [31:0] e_data [NI];
  logic        e_en [NI], e_part [NI], e_all [NI];

  task automatic step(input logic s, input logic e);
    int p;
    @(negedge clk);
    srst = s;
    enbl = e;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (s) begin
        cnt[i] = 0; e_data[i] = '0; e_en[i] = 0; e_part[i] = 0; e_all[i] = 0;
      end else if (e) begin
        p = cnt[i] % (2 * pl[i]);
        e_data[i] = exp_word(pw[i], pl[i], pinv[i], cnt[i]);
        e_en[i]   = 1'b1;
        e_part[i] = (p % pl[i] == 0);
        e_all[i]  = (p == 0);
        cnt[i]++;
      end else begin
        e_en[i] = 0; e_part[i] = 0; e_all[i] = 0;
      end
      chk($sformatf("u%0d.wr_enbl", i), {31'd0, g_en[i]}, {31'd0, e_en[i]});
      chk($sformatf("u%0d.wr_data", i), g_data[i], e_data[i]);
      chk($sformatf("u%0d.part", i), {31'd0, g_part[i]}, {31'd0, e_part[i]});
      chk($sformatf("u%0d.all", i), {31'd0, g_all[i]}, {31'd0, e_all[i]});
    end
  endtask

  initial begin
    srst = 1'b1;
    enbl = 1'b0;
    for (int i = 0; i < NI; i++) cnt[i] = 0;
    repeat (3) step(1'b1, 1'b1);
    // Full two-pass stream, then a pause after word 3 of the next cycle.
    repeat (20) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);
    // Reset mid-stream.
    step(1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1);
    repeat (600) step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
